// File: rtl/cp0_defs.sv
// cp0_defs: CP0 register numbers, exception type codes and field layout shared by
// the CP0 register file and the exception encoder.
package cp0_defs;
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000A;
    localparam logic [31:0] EXC_OV   = 32'h0000_000C;
    localparam logic [31:0] EXC_ERET = 32'h0000_000E;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_BD   = 31;
    function automatic logic is_exception(input logic [31:0] t);
        return t inside {EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV};
    endfunction
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare pair; Count advances every second cycle and a match
// latches the timer interrupt until Compare is rewritten.
module cp0_timer
    import cp0_defs::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        toggle_q, timer_int_q, timer_int_d;

    always_comb begin
        count_d     = count_we_i ? wdata_i : count_q + {31'd0, toggle_q};
        compare_d   = compare_we_i ? wdata_i : compare_q;
        timer_int_d = compare_we_i ? 1'b0 : (count_q == compare_q) | timer_int_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q     <= '0;
            compare_q   <= '0;
            toggle_q    <= 1'b0;
            timer_int_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            compare_q   <= compare_d;
            toggle_q    <= ~toggle_q;
            timer_int_q <= timer_int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;
endmodule

// File: rtl/cp0_regs.sv
// cp0_regs: MIPS CP0 register file (Status, Cause, EPC, BadVAddr plus timer) with
// mtc0/mfc0 access and exception/eret state updates.
module cp0_regs
    import cp0_defs::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] rdata_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);
    logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic        take_exc;

    cp0_timer u_timer (
        .clk          (clk),
        .resetn       (resetn),
        .count_we_i   (we_i && waddr_i == CP0_COUNT),
        .compare_we_i (we_i && waddr_i == CP0_COMPARE),
        .wdata_i      (wdata_i),
        .count_o      (count_o),
        .compare_o    (compare_o),
        .timer_int_o  (timer_int_o)
    );

    assign take_exc = is_exception(excepttype_i);

    // mtc0 is applied first so exception/eret updates override only the fields they own
    always_comb begin
        status_d   = (we_i && waddr_i == CP0_STATUS) ? (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK) : status_q;
        cause_d    = (we_i && waddr_i == CP0_CAUSE) ? (cause_q & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK) : cause_q;
        epc_d      = (we_i && waddr_i == CP0_EPC) ? wdata_i : epc_q;
        badvaddr_d = badvaddr_q;
        cause_d[15:10] = {int_i[5] | timer_int_o, int_i[4:0]};
        if (take_exc) begin
            cause_d[6:2]         = (excepttype_i == EXC_INT) ? 5'd0 : excepttype_i[4:0];
            status_d[STATUS_EXL] = 1'b1;
            if (!status_q[STATUS_EXL]) begin
                epc_d             = is_in_delayslot_i ? pc_i - 32'd4 : pc_i;
                cause_d[CAUSE_BD] = is_in_delayslot_i;
            end
            if (excepttype_i == EXC_ADEL || excepttype_i == EXC_ADES) badvaddr_d = bad_addr_i;
        end else if (excepttype_i == EXC_ERET) begin
            status_d[STATUS_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q   <= STATUS_RESET;
            cause_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    assign rdata_o = (raddr_i == CP0_BADVADDR) ? badvaddr_q :
                     (raddr_i == CP0_COUNT)    ? count_o    :
                     (raddr_i == CP0_COMPARE)  ? compare_o  :
                     (raddr_i == CP0_STATUS)   ? status_q   :
                     (raddr_i == CP0_CAUSE)    ? cause_q    :
                     (raddr_i == CP0_EPC)      ? epc_q      : 32'd0;

    assign status_o   = status_q;
    assign cause_o    = cause_q;
    assign epc_o      = epc_q;
    assign badvaddr_o = badvaddr_q;
endmodule

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs: directed and randomized checks of cp0_regs against a behavioural CP0 model.
module tb_cp0_regs;
    logic        clk = 1'b0, resetn = 1'b0, we_i = 1'b0, is_in_delayslot_i = 1'b0;
    logic [4:0]  waddr_i = '0, raddr_i = '0;
    logic [31:0] wdata_i = '0, excepttype_i = '0, pc_i = '0, bad_addr_i = '0;
    logic [5:0]  int_i = '0;
    logic [31:0] rdata_o, status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;
    logic        timer_int_o;
    int n_assert = 0, n_fail = 0;
    logic [31:0] m_status, m_cause, m_epc, m_bad, m_count, m_cmp;
    logic        m_ti;
    int unsigned m_cyc;

    cp0_regs dut (
        .clk(clk), .resetn(resetn), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .int_i(int_i), .excepttype_i(excepttype_i), .pc_i(pc_i),
        .is_in_delayslot_i(is_in_delayslot_i), .bad_addr_i(bad_addr_i), .rdata_o(rdata_o),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o),
        .count_o(count_o), .compare_o(compare_o), .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd11:   return m_cmp;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_status = 32'h0040_0000;
        {m_cause, m_epc, m_bad, m_count, m_cmp} = '0;
        m_ti = 1'b0;
        m_cyc = 0;
    endtask

    task automatic check_all(input string tag);
        raddr_i = 5'($urandom_range(0, 31));
        #1;
        chk({tag, ":status"}, status_o, m_status);
        chk({tag, ":cause"}, cause_o, m_cause);
        chk({tag, ":epc"}, epc_o, m_epc);
        chk({tag, ":badvaddr"}, badvaddr_o, m_bad);
        chk({tag, ":count"}, count_o, m_count);
        chk({tag, ":compare"}, compare_o, m_cmp);
        chk({tag, ":timer_int"}, {31'd0, timer_int_o}, {31'd0, m_ti});
        chk({tag, ":rdata"}, rdata_o, m_read(raddr_i));
    endtask

    task automatic step(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [31:0] exc, input logic [31:0] pc, input logic ds,
                        input logic [31:0] bad, input logic [5:0] irq);
        logic [31:0] n_status, n_cause, n_epc, n_bad, n_count, n_cmp;
        logic        n_ti;
        bit          is_exc;
        we_i = we; waddr_i = wa; wdata_i = wd; excepttype_i = exc; pc_i = pc;
        is_in_delayslot_i = ds; bad_addr_i = bad; int_i = irq;
        n_count = (m_cyc % 2 == 1) ? m_count + 1 : m_count;
        if (we && wa == 9) n_count = wd;
        n_cmp = (we && wa == 11) ? wd : m_cmp;
        n_ti = (we && wa == 11) ? 1'b0 : (m_ti || m_count == m_cmp);
        n_status = m_status;
        n_cause = m_cause;
        n_epc = (we && wa == 14) ? wd : m_epc;
        n_bad = m_bad;
        if (we && wa == 12) n_status = (m_status & 32'hFFFF_00FC) | (wd & 32'h0000_FF03);
        if (we && wa == 13) n_cause[9:8] = wd[9:8];
        n_cause[15] = irq[5] | m_ti;
        n_cause[14:10] = irq[4:0];
        is_exc = (exc == 1) || (exc == 4) || (exc == 5) || (exc == 8) || (exc == 9) || (exc == 10) || (exc == 12);
        if (is_exc) begin
            n_cause[6:2] = (exc == 1) ? 5'd0 : exc[4:0];
            if (m_status[1] == 1'b0) begin
                n_epc = ds ? pc - 4 : pc;
                n_cause[31] = ds;
            end
            n_status[1] = 1'b1;
            if (exc == 4 || exc == 5) n_bad = bad;
        end else if (exc == 14) begin
            n_status[1] = 1'b0;
        end
        @(posedge clk);
        #1;
        {m_status, m_cause, m_epc, m_bad, m_count, m_cmp, m_ti} = {n_status, n_cause, n_epc, n_bad, n_count, n_cmp, n_ti};
        m_cyc++;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0);
    endtask

    initial begin
        logic [4:0]  regs [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0};
        logic [31:0] excs [12] = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hC, 32'hE, 32'h0};
        logic [31:0] saved_epc;
        model_reset();
        #12;
        check_all("reset_init");
        @(negedge clk) resetn = 1'b1;
        for (int i = 0; i < 7; i++) idle("run");
        #2 resetn = 1'b0;
        #1;
        model_reset();
        chk("rst_status_now", status_o, 32'h0040_0000);
        chk("rst_count_now", count_o, 32'd0);
        check_all("reset_mid");
        @(negedge clk) resetn = 1'b1;
        idle("post_rst1");
        idle("post_rst2");
        chk("count_after_2", count_o, 32'd1);

        step("wr_cmp10", 1'b1, 5'd11, 32'd10, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0);
        step("wr_cnt0", 1'b1, 5'd9, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0);
        for (int i = 0; i < 40 && count_o !== 32'd10; i++) idle("wait10");
        chk("count_reach10", count_o, 32'd10);
        idle("tmatch");
        chk("timer_int_set", {31'd0, timer_int_o}, 32'd1);
        idle("tip7");
        chk("cause_ip7", {31'd0, cause_o[15]}, 32'd1);
        step("wr_cmp20", 1'b1, 5'd11, 32'd20, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0);
        chk("timer_int_clr", {31'd0, timer_int_o}, 32'd0);

        step("eret_pre", 1'b0, 5'd0, 32'd0, 32'hE, 32'd0, 1'b0, 32'd0, 6'd0);
        step("syscall_ds", 1'b0, 5'd0, 32'd0, 32'h8, 32'hBFC0_0104, 1'b1, 32'd0, 6'd0);
        chk("sys_epc", epc_o, 32'hBFC0_0100);
        chk("sys_bd", {31'd0, cause_o[31]}, 32'd1);
        chk("sys_exccode", {27'd0, cause_o[6:2]}, 32'd8);
        chk("sys_exl", {31'd0, status_o[1]}, 32'd1);
        saved_epc = m_epc;
        step("adel_exl1", 1'b0, 5'd0, 32'd0, 32'h4, 32'h1234_5678, 1'b0, 32'h3, 6'd0);
        chk("adel_bad", badvaddr_o, 32'h3);
        chk("adel_exccode", {27'd0, cause_o[6:2]}, 32'd4);
        chk("adel_epc_keep", epc_o, saved_epc);
        step("eret_mtc0", 1'b1, 5'd12, 32'h0000_FF03, 32'hE, 32'd0, 1'b0, 32'd0, 6'd0);
        chk("eret_im", {24'd0, status_o[15:8]}, 32'hFF);
        chk("eret_ie", {31'd0, status_o[0]}, 32'd1);
        chk("eret_exl", {31'd0, status_o[1]}, 32'd0);
        if (m_cyc % 2 == 0) idle("align");
        step("cnt_wr_inc", 1'b1, 5'd9, 32'h100, 32'd0, 32'd0, 1'b0, 32'd0, 6'd0);
        chk("cnt_wr_prec", count_o, 32'h100);

        for (int i = 0; i < 400; i++) begin
            logic [4:0]  wa;
            logic [31:0] ex, wd;
            wa = ($urandom_range(0, 7) == 0) ? 5'($urandom) : regs[$urandom_range(0, 6)];
            ex = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 31)) : excs[$urandom_range(0, 11)];
            wd = (wa == 5'd11 && $urandom_range(0, 1) == 1) ? m_count + 32'($urandom_range(0, 4)) : $urandom;
            step("rand", 1'($urandom_range(0, 1)), wa, wd, ex, $urandom, 1'($urandom),
                 $urandom, 6'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
